// File: rtl/alu_decode_queue.sv
// RV32I ALU-class decoder with a DEPTH-entry output FIFO of decoded records.
// Optional macro DEC_ILLEGAL_TRAP_EN: drop illegal instructions and raise a sticky illegal flag.
module alu_decode_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  ALUOp,
    output logic        use_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic [3:0]  aluOp;
        logic        useImm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regWrite;
    } rec_t;

    rec_t           dec;
    logic           decIllegal;
    logic [2:0]     funct3;
    logic [6:0]     funct7;

    rec_t           mem_q [DEPTH];
    logic [PW-1:0]  wrPtr_q, wrPtr_d;
    logic [PW-1:0]  rdPtr_q, rdPtr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push;
    logic           pop;
    rec_t           head;

    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Illegal words are squashed to a harmless no-write record so the default build can pass them through.
    always_comb begin
        dec        = '0;
        decIllegal = 1'b0;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];
        case (instr[6:0])
            OPC_OP: begin
                dec.aluOp    = {funct7[5], funct3};
                dec.regWrite = 1'b1;
                decIllegal   = !((funct7 == 7'b0000000) ||
                                 ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_OP_IMM: begin
                dec.useImm   = 1'b1;
                dec.imm      = {{20{instr[31]}}, instr[31:20]};
                dec.regWrite = 1'b1;
                dec.aluOp    = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
                if (funct3 == 3'b001) begin
                    decIllegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    decIllegal = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
                end
            end
            OPC_LOAD: begin
                dec.useImm   = 1'b1;
                dec.imm      = {{20{instr[31]}}, instr[31:20]};
                dec.regWrite = 1'b1;
            end
            OPC_STORE: begin
                dec.useImm = 1'b1;
                dec.imm    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            default: decIllegal = 1'b1;
        endcase
        if (dec.rd == 5'd0) begin
            dec.regWrite = 1'b0;
        end
        if (decIllegal) begin
            dec.aluOp    = 4'b0000;
            dec.useImm   = 1'b0;
            dec.imm      = '0;
            dec.regWrite = 1'b0;
        end
    end

    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

`ifdef DEC_ILLEGAL_TRAP_EN
    logic illegal_q;

    assign push    = in_valid && in_ready && !decIllegal;
    assign illegal = illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (in_valid && in_ready && decIllegal) begin
            illegal_q <= 1'b1;
        end
    end
`else
    assign push    = in_valid && in_ready;
    assign illegal = 1'b0;
`endif

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= dec;
        end
    end

    assign head = out_valid ? mem_q[rdPtr_q] : '0;

    assign ALUOp     = head.aluOp;
    assign use_imm   = head.useImm;
    assign imm       = head.imm;
    assign rs1       = head.rs1;
    assign rs2       = head.rs2;
    assign rd        = head.rd;
    assign reg_write = head.regWrite;

endmodule

// File: doc/alu_decode_queue.md
ALU_DECODE_QUEUE -- requirements
Module: alu_decode_queue

Interface
REQ-001 Parameter DEPTH, default 2, output buffer entries (legal 2..4).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  instr carries a valid instruction word.
REQ-005 in_ready  output  1  block accepts instr this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 out_valid  output  1  head entry valid.
REQ-008 out_ready  input  1  consumer takes head entry this cycle.
REQ-009 ALUOp  output  4  operation code for the ALU, same encoding as the ALU's ALUOp.
REQ-010 use_imm  output  1  operand B is imm, not rs2 data.
REQ-011 imm  output  32  sign-extended immediate.
REQ-012 rs1, rs2, rd  output  5 each  register indices.
REQ-013 reg_write  output  1  result written to rd.
REQ-014 illegal  output  1  sticky illegal-instruction flag (see REQ-030).

Function
REQ-015 Transfer in: in_valid & in_ready at a rising edge; transfer out: out_valid & out_ready.
REQ-016 in_ready SHALL equal (count < DEPTH), registered-state only, independent of out_ready.
REQ-017 Decode is combinational on instr; the decoded record is written into a DEPTH-entry FIFO on input transfer.
REQ-018 Latency: instruction accepted at edge N appears with out_valid=1 after edge N when the FIFO was empty; no combinational in-to-out path.
REQ-019 Outputs ALUOp..reg_write reflect the FIFO head; when out_valid=0 they SHALL be 0.
REQ-020 OP (0110011): ALUOp={funct7[5],funct3}, use_imm=0, reg_write=1; legal iff funct7=0000000, or funct7=0100000 with funct3 in {000,101}.
REQ-021 OP-IMM (0010011): use_imm=1, imm=sext(instr[31:20]), reg_write=1; ALUOp={funct7[5],funct3} when funct3=101, else {0,funct3}; funct3=001 legal iff funct7=0000000; funct3=101 legal iff funct7 in {0000000,0100000}.
REQ-022 LOAD (0000011): ALUOp=0000, use_imm=1, imm=sext(instr[31:20]), reg_write=1.
REQ-023 STORE (0100011): ALUOp=0000, use_imm=1, imm=sext({instr[31:25],instr[11:7]}), reg_write=0.
REQ-024 rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7] for every opcode; rd=0 forces reg_write=0.
REQ-025 Any other opcode is illegal.
REQ-026 Simultaneous push and pop: count unchanged, order preserved; when full, in_ready=0, so no push even if out_ready=1 that cycle.
REQ-027 Read/write pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-028 Pop while empty and push while full SHALL be ignored without state change.

Reset
REQ-029 rst=1 immediately clears count, pointers and illegal: out_valid=0, in_ready=1, all decoded outputs 0, regardless of clock; in-flight entries are discarded.

Configuration
REQ-030 Macro DEC_ILLEGAL_TRAP_EN defined: an accepted illegal instruction is not enqueued and sets illegal=1, which stays set until reset; subsequent legal instructions continue to flow.
REQ-031 DEC_ILLEGAL_TRAP_EN undefined: illegal is tied 0; an illegal instruction is enqueued with ALUOp=0000, use_imm=0, reg_write=0.

Verification
REQ-032 Reset, then push instr 0x40208033 (sub x0? use rd=1: 0x402080B3) with out_ready=1 -> next cycle out_valid=1, ALUOp=1000, rd=1, rs1=1, rs2=2, reg_write=1, use_imm=0.
REQ-033 Push 0x4030D093 (srai x1,x1,3) -> ALUOp=1101, use_imm=1, imm=0x00000403, reg_write=1.
REQ-034 out_ready=0, push 3 legal instructions with DEPTH=2 -> in_ready=0 after second accept, third held; raise out_ready -> entries emerge in order, count never exceeds 2.
REQ-035 FIFO at count=1, push and pop same cycle repeatedly over 5 cycles -> count stays 1, in-order outputs, pointers wrap correctly.
REQ-036 Push 0xFFFFFFFF with DEC_ILLEGAL_TRAP_EN -> nothing enqueued, illegal=1 persisting; without macro -> entry with ALUOp=0000, reg_write=0, illegal=0.
REQ-037 Assert rst mid-burst with FIFO full -> same cycle out_valid=0, in_ready=1, illegal=0 before the next clock edge.
